// File: rtl/rtsnoc_echo_initiator.sv
// Echo initiator/checker on an RTSNoC local port: sends a numbered burst of single-flit requests and checks each echoed reply.
// Registered outputs; a write is held until wait_i drops, and unexpected flits are drained with single-cycle rd_o pulses.
module rtsnoc_echo_initiator #(
  parameter int                    SOC_SIZE_X     = 1,
  parameter int                    SOC_SIZE_Y     = 1,
  parameter int                    NOC_DATA_WIDTH = 16,
  parameter logic [SOC_SIZE_X-1:0] LOCAL_X        = '0,
  parameter logic [SOC_SIZE_Y-1:0] LOCAL_Y        = '0,
  parameter logic [2:0]            LOCAL_H        = 3'd0,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter int                    CNT_WIDTH      = 16
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic                                                   start_i,
  input  logic [CNT_WIDTH-1:0]                                   count_i,
  input  logic [NOC_DATA_WIDTH-1:0]                              seed_i,
  input  logic [SOC_SIZE_X-1:0]                                  dst_x_i,
  input  logic [SOC_SIZE_Y-1:0]                                  dst_y_i,
  input  logic [2:0]                                             dst_h_i,
  output logic [NOC_DATA_WIDTH+2*SOC_SIZE_X+2*SOC_SIZE_Y+5:0]    din_o,
  output logic                                                   wr_o,
  input  logic                                                   wait_i,
  input  logic [NOC_DATA_WIDTH+2*SOC_SIZE_X+2*SOC_SIZE_Y+5:0]    dout_i,
  input  logic                                                   nd_i,
  output logic                                                   rd_o,
  output logic                                                   busy_o,
  output logic                                                   done_o,
  output logic [CNT_WIDTH-1:0]                                   pass_cnt_o,
  output logic [CNT_WIDTH-1:0]                                   fail_cnt_o,
  output logic [CNT_WIDTH-1:0]                                   stray_cnt_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [SOC_SIZE_X-1:0]     orig_x;
    logic [SOC_SIZE_Y-1:0]     orig_y;
    logic [2:0]                orig_h;
    logic [SOC_SIZE_X-1:0]     dst_x;
    logic [SOC_SIZE_Y-1:0]     dst_y;
    logic [2:0]                dst_h;
    logic [NOC_DATA_WIDTH-1:0] data;
  } flit_t;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, READ, CHECK, DONE} state_t;

  state_t                    state;
  logic [SOC_SIZE_X-1:0]     dst_x;
  logic [SOC_SIZE_Y-1:0]     dst_y;
  logic [2:0]                dst_h;
  logic [CNT_WIDTH-1:0]      count;
  logic [CNT_WIDTH-1:0]      idx;
  logic [NOC_DATA_WIDTH-1:0] data;
  logic [TW-1:0]             timer;
  flit_t                     rx;

  logic [CNT_WIDTH-1:0]      idx_nxt;
  logic [NOC_DATA_WIDTH-1:0] data_nxt;
  logic                      reply_now;
  logic                      timeout;
  logic                      rx_ok;
  logic                      adv;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    idx_nxt   = idx + 1'b1;
    data_nxt  = data + 1'b1;
    // nd_i is not looked at during an rd_o cycle: it still flags the flit being read
    reply_now = nd_i && !rd_o;
    timeout   = (timer == TMAX);
    rx_ok     = (rx.orig_x == dst_x) && (rx.orig_y == dst_y) && (rx.orig_h == dst_h) &&
                (rx.dst_x == LOCAL_X) && (rx.dst_y == LOCAL_Y) && (rx.dst_h == LOCAL_H) &&
                (rx.data == data);
    adv       = ((state == WAIT) && !reply_now && timeout) || (state == CHECK);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      din_o       <= '0;
      wr_o        <= 1'b0;
      rd_o        <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_cnt_o  <= '0;
      fail_cnt_o  <= '0;
      stray_cnt_o <= '0;
      dst_x       <= '0;
      dst_y       <= '0;
      dst_h       <= '0;
      count       <= '0;
      idx         <= '0;
      data        <= '0;
      timer       <= '0;
      rx          <= '0;
    end else begin
      done_o <= 1'b0;

      // Stray drain: runs alongside the FSM so a pending write in SEND is untouched
      if (rd_o) begin
        rd_o <= 1'b0;
        if (state != READ) stray_cnt_o <= sat_inc(stray_cnt_o);
      end else if (nd_i && (state == IDLE || state == SEND || state == DONE)) begin
        rd_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            dst_x       <= dst_x_i;
            dst_y       <= dst_y_i;
            dst_h       <= dst_h_i;
            count       <= count_i;
            idx         <= '0;
            data        <= seed_i;
            pass_cnt_o  <= '0;
            fail_cnt_o  <= '0;
            stray_cnt_o <= '0;
            if (count_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state  <= SEND;
              busy_o <= 1'b1;
              wr_o   <= 1'b1;
              din_o  <= {LOCAL_X, LOCAL_Y, LOCAL_H, dst_x_i, dst_y_i, dst_h_i, seed_i};
            end
          end
        end
        SEND: begin
          if (!wait_i) begin
            wr_o  <= 1'b0;
            timer <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (reply_now) begin
            rd_o  <= 1'b1;
            state <= READ;
          end else if (!timeout) begin
            timer <= timer + 1'b1;
          end else begin
            fail_cnt_o <= sat_inc(fail_cnt_o);
          end
        end
        READ: begin
          rx    <= dout_i;
          state <= CHECK;
        end
        CHECK: begin
          if (rx_ok) pass_cnt_o <= sat_inc(pass_cnt_o);
          else       fail_cnt_o <= sat_inc(fail_cnt_o);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (adv) begin
        idx  <= idx_nxt;
        data <= data_nxt;
        if (idx_nxt == count) begin
          state  <= DONE;
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end else begin
          state <= SEND;
          wr_o  <= 1'b1;
          din_o <= {LOCAL_X, LOCAL_Y, LOCAL_H, dst_x, dst_y, dst_h, data_nxt};
        end
      end
    end
  end

endmodule
